elbeth_dmem_bridge: RTL and testbench
=====================================

# elbeth_dmem_bridge

Data-side bridge between the elbeth_core data port and port B of elbeth_memory. Latches each core request, converts the byte address to a word address, and checks range and byte-enable legality. It then drives a single memory access, waits for the memory ready, and returns one ready pulse, with error when applicable, to the core. Illegal or timed-out accesses never corrupt memory and are recorded in a fault register for debug.

## Interface
- ADDR_WIDTH, 8, word-address width of the memory port; the legal byte window is 0 .. 2^(ADDR_WIDTH+2)-1.
- TIMEOUT, 16, maximum cycles spent waiting for mem_ready before the access is aborted with an error.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- core_en  in  1  request strobe from the core.
- core_addr  in  32  byte address.
- core_rw  in  4  byte write enables; 4'b0000 means full-word read.
- core_wdata  in  32  write data, byte lanes aligned to the word.
- core_rdata  out  32  read data, valid while core_ready=1.
- core_ready  out  1  one-cycle completion pulse.
- core_error  out  1  qualifies core_ready; the access faulted.
- mem_en  out  1  memory request, held until mem_ready.
- mem_addr  out  ADDR_WIDTH  word address, equal to core_addr[ADDR_WIDTH+1:2].
- mem_rw  out  4  byte enables forwarded.
- mem_wdata  out  32  write data forwarded.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory completion.
- err_addr  out  32  byte address of the most recent faulting request.
- err_cause  out  2  cause code: 0 none, 1 out of range, 2 illegal byte enables, 3 timeout.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, core_en=1: latch core_addr, core_rw and core_wdata, then decode. The core may deassert or change its inputs afterwards.
  - Out of range, meaning core_addr[31:ADDR_WIDTH+2] is nonzero: go to RESP with error, cause 1.
  - core_rw not one of 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111: go to RESP with error, cause 2. Range is checked first when both faults apply.
  - Otherwise go to ACCESS and clear the timeout counter.
- ACCESS: mem_en=1 with the latched address, enables and data.
  - mem_ready=1: register mem_rdata on a read, or 0 on a write, and go to RESP with no error.
  - Otherwise increment the counter. When the counter equals TIMEOUT-1 and mem_ready=0, go to RESP with error, cause 3.
- RESP: core_ready=1 for exactly one cycle, then return to IDLE. core_en is ignored while in ACCESS or RESP.
- Fault recording: on entry to RESP with error, load err_addr and err_cause. Both hold until the next fault or until reset; successful accesses do not clear them.
- core_rdata is 0 on any error response.
- Byte enables are not rewritten by address[1:0]. Lane selection is the core's responsibility; the bridge only checks the pattern.

## Timing
- Reset: state IDLE and counter 0. All outputs are 0: core_ready, core_error, core_rdata, mem_en, mem_addr, mem_rw, mem_wdata, err_addr, err_cause.
- Reset asserted mid-access: mem_en drops in the next cycle. No core_ready is issued for the aborted request, and a mem_ready arriving after reset is ignored.
- Request sampled at cycle T.
  - Legal request: mem_en=1 from T+1.
  - mem_ready first high at cycle T+k (k≥1): mem_en=0 and core_ready=1 at T+k+1; the next request can be sampled at T+k+2.
  - Zero-wait memory (mem_ready high at T+1) gives core_ready at T+2 and a minimum repeat period of 3 cycles.
- Decode error: core_ready=core_error=1 at T+1, with mem_en never asserted.
- Timeout: mem_en is high for exactly TIMEOUT cycles, T+1 through T+TIMEOUT. Error response at T+TIMEOUT+1.
- mem_ready arriving on the same cycle the counter reaches TIMEOUT-1 counts as success; ready wins over timeout.
- mem_ready seen while IDLE or RESP is ignored.

## Test plan
- Read word: after reset, core_addr=0x0000_0010, rw=0, memory answers 0xDEADBEEF on the first cycle. Required: mem_addr=0x04 at T+1, core_ready=1 with core_rdata=0xDEADBEEF and core_error=0 at T+2.
- Byte write: rw=4'b0100, addr=0x0000_0022, wdata=0x00AB_0000, memory ready after 3 cycles. Required: mem_addr=0x08 and mem_rw=0100 held for 3 cycles; core_ready at T+4; core_rdata=0.
- Out of range: addr=0x0000_0400. Required: core_ready=core_error=1 at T+1, mem_en stays 0, err_addr=0x400, err_cause=1.
- Illegal enables: rw=4'b0110 at addr 0. Required: error at T+1, err_cause=2; a following legal read succeeds and err_cause remains 2.
- Timeout: mem_ready tied low, TIMEOUT=16. Required: mem_en high for 16 cycles, error response at T+17, err_cause=3. Repeat with mem_ready arriving on the 16th cycle: success, no error.
- Reset mid-access: assert rst during ACCESS, then pulse mem_ready. Required: all outputs 0 on the cycle after reset, no core_ready ever issued, and the state returns to IDLE.

Source files
------------

// File: rtl/elbeth_dmem_bridge_if.sv
// rtl/elbeth_dmem_bridge_if.sv - core-side, memory-side and fault signals of the data bridge
interface elbeth_dmem_bridge_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  core_en;
    logic [31:0]           core_addr;
    logic [3:0]            core_rw;
    logic [31:0]           core_wdata;
    logic [31:0]           core_rdata;
    logic                  core_ready;
    logic                  core_error;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_rw;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;
    logic [31:0]           err_addr;
    logic [1:0]            err_cause;

    // Bridge view
    modport slave (
        input  core_en, core_addr, core_rw, core_wdata, mem_rdata, mem_ready,
        output core_rdata, core_ready, core_error, mem_en, mem_addr, mem_rw,
               mem_wdata, err_addr, err_cause
    );

    // Environment view (core + memory)
    modport master (
        output core_en, core_addr, core_rw, core_wdata, mem_rdata, mem_ready,
        input  core_rdata, core_ready, core_error, mem_en, mem_addr, mem_rw,
               mem_wdata, err_addr, err_cause
    );
endinterface

// File: rtl/elbeth_dmem_bridge.sv
// rtl/elbeth_dmem_bridge.sv - core data port to memory port B bridge with range/enable checks and timeout
module elbeth_dmem_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    elbeth_dmem_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [31:0]        addr_q;
    logic [3:0]         rw_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [31:0]        err_addr_q;
    logic [1:0]         err_cause_q;

    logic               latch;
    logic               finish;
    logic               fin_err;
    logic [1:0]         fin_cause;
    logic [31:0]        fin_addr;
    logic [31:0]        fin_rdata;
    logic [31:0]        addr_hi;
    logic               out_of_range;
    logic               rw_legal;

    always_comb begin
        addr_hi      = bus.core_addr >> (ADDR_WIDTH + 2);
        out_of_range = |addr_hi;
        case (bus.core_rw)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: rw_legal = 1'b1;
            default:                   rw_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        latch     = 1'b0;
        finish    = 1'b0;
        fin_err   = 1'b0;
        fin_cause = 2'd0;
        fin_addr  = addr_q;
        fin_rdata = '0;
        case (state)
            IDLE: begin
                if (bus.core_en) begin
                    latch    = 1'b1;
                    fin_addr = bus.core_addr;
                    // Range fault takes priority over an illegal enable pattern
                    if (out_of_range) begin
                        state_d   = RESP;
                        finish    = 1'b1;
                        fin_err   = 1'b1;
                        fin_cause = 2'd1;
                    end else if (!rw_legal) begin
                        state_d   = RESP;
                        finish    = 1'b1;
                        fin_err   = 1'b1;
                        fin_cause = 2'd2;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                // Ready wins over timeout on the last allowed cycle
                if (bus.mem_ready) begin
                    state_d   = RESP;
                    finish    = 1'b1;
                    fin_rdata = (rw_q == 4'b0000) ? bus.mem_rdata : '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    finish    = 1'b1;
                    fin_err   = 1'b1;
                    fin_cause = 2'd3;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rw_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= '0;
        end else begin
            if (latch) begin
                addr_q  <= bus.core_addr;
                rw_q    <= bus.core_rw;
                wdata_q <= bus.core_wdata;
            end
            if (finish) begin
                rdata_q <= fin_rdata;
                err_q   <= fin_err;
                if (fin_err) begin
                    err_addr_q  <= fin_addr;
                    err_cause_q <= fin_cause;
                end
            end
        end
    end

    assign bus.core_ready = (state == RESP);
    assign bus.core_error = (state == RESP) && err_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_en     = (state == ACCESS);
    assign bus.mem_addr   = addr_q[ADDR_WIDTH+1:2];
    assign bus.mem_rw     = rw_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.err_cause  = err_cause_q;
endmodule

// File: tb/tb_elbeth_dmem_bridge.sv
// tb/tb_elbeth_dmem_bridge.sv - scoreboard bench for elbeth_dmem_bridge
module tb_elbeth_dmem_bridge;
    localparam int AW      = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elbeth_dmem_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    elbeth_dmem_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] model_mem [0:(1<<AW)-1];
    logic [31:0] exp_err_addr  = '0;
    logic [1:0]  exp_err_cause = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Response monitor: every core_ready pops one expected {error, rdata}
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("core_error", {31'd0, bus.core_error}, {31'd0, e[32]});
                    check("core_rdata", bus.core_rdata, e[31:0]);
                end
            end
        end
    end

    // Issue one request from IDLE; k = cycle of first mem_ready (0 = never).
    // cause: 0 legal, 1 range, 2 enables, 3 expected timeout.
    task automatic run_req(input logic [31:0] addr, input logic [3:0] rw, input logic [31:0] wd,
                           input int k, input logic [1:0] cause);
        int          exp_lat, exp_en, lat, en_cnt, hold_ok;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [AW-1:0] w;
        w       = addr[AW+1:2];
        exp_rd  = '0;
        exp_err = 1'b1;
        if (cause == 2'd1 || cause == 2'd2) begin
            exp_lat = 1; exp_en = 0;
        end else if (cause == 2'd3) begin
            exp_lat = TIMEOUT + 1; exp_en = TIMEOUT;
        end else begin
            exp_lat = k + 1; exp_en = k; exp_err = 1'b0;
            if (rw == 4'b0000) exp_rd = model_mem[w];
        end
        exp_q.push_back({exp_err, exp_rd});

        bus.core_en    = 1'b1;
        bus.core_addr  = addr;
        bus.core_rw    = rw;
        bus.core_wdata = wd;
        @(posedge clk);
        #1;
        bus.core_en    = 1'b0;
        bus.core_addr  = $urandom;
        bus.core_rw    = 4'($urandom);
        bus.core_wdata = $urandom;

        lat = -1; en_cnt = 0; hold_ok = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.core_ready === 1'b1) begin
                lat = cyc;
                break;
            end
            if (bus.mem_en === 1'b1) begin
                en_cnt++;
                if (bus.mem_addr === w && bus.mem_rw === rw && bus.mem_wdata === wd) hold_ok++;
            end
            bus.mem_ready = (cyc == k);
            bus.mem_rdata = (rw == 4'b0000) ? model_mem[w] : $urandom;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;

        check("latency", lat, exp_lat);
        check("mem_en_cycles", en_cnt, exp_en);
        check("mem_fields_held", hold_ok, exp_en);
        if (exp_err) begin
            exp_err_addr  = addr;
            exp_err_cause = cause;
        end else begin
            for (int i = 0; i < 4; i++)
                if (rw[i]) model_mem[w][8*i +: 8] = wd[8*i +: 8];
        end
        check("err_addr", bus.err_addr, exp_err_addr);
        check("err_cause", {30'd0, bus.err_cause}, {30'd0, exp_err_cause});
        @(posedge clk);
        #1;
        check("ready_pulse", {31'd0, bus.core_ready}, 32'd0);
    endtask

    logic [3:0] legal_rw [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        logic [31:0] a;
        int          seen;
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = $urandom;
        model_mem[4]   = 32'hDEAD_BEEF;
        bus.core_en    = 1'b0;
        bus.core_addr  = '0;
        bus.core_rw    = '0;
        bus.core_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {bus.core_ready, bus.core_error, bus.mem_en, bus.mem_rw, bus.err_cause},
              32'd0);
        check("rst_data", bus.core_rdata | bus.mem_wdata | bus.err_addr | 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_req(32'h0000_0010, 4'b0000, 32'h0, 1, 2'd0);
        run_req(32'h0000_0022, 4'b0100, 32'h00AB_0000, 3, 2'd0);
        run_req(32'h0000_0400, 4'b0000, 32'h0, 1, 2'd1);
        run_req(32'h0000_0000, 4'b0110, 32'h0, 1, 2'd2);
        run_req(32'h0000_0020, 4'b0000, 32'h0, 2, 2'd0);
        run_req(32'h8000_0800, 4'b0110, 32'h0, 1, 2'd1);
        run_req(32'h0000_0104, 4'b1111, 32'h1234_5678, 0, 2'd3);
        run_req(32'h0000_0104, 4'b0000, 32'h0, TIMEOUT, 2'd0);
        run_req(32'h0000_03FC, 4'b1100, 32'hCAFE_0000, 1, 2'd0);
        run_req(32'h0000_03FC, 4'b0000, 32'h0, 1, 2'd0);

        // Reset while waiting on memory; a late mem_ready must be ignored
        bus.core_en   = 1'b1;
        bus.core_addr = 32'h0000_0040;
        bus.core_rw   = 4'b0000;
        @(posedge clk);
        #1;
        bus.core_en = 1'b0;
        check("mid_mem_en", {31'd0, bus.mem_en}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_outputs", {bus.core_ready, bus.core_error, bus.mem_en, bus.mem_rw, bus.err_cause},
              32'd0);
        check("mid_rst_data", bus.core_rdata | bus.mem_wdata | bus.err_addr | 32'(bus.mem_addr), 32'd0);
        exp_err_addr  = '0;
        exp_err_cause = '0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            if (bus.core_ready === 1'b1 || bus.mem_en === 1'b1) seen++;
        end
        check("post_rst_quiet", seen, 0);
        run_req(32'h0000_0040, 4'b0000, 32'h0, 2, 2'd0);

        for (int n = 0; n < 10; n++) begin
            a = {22'd0, 10'($urandom)};
            run_req(a, legal_rw[$urandom_range(0, 7)], $urandom, $urandom_range(1, 5), 2'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
